snake_step_ctrl: RTL and testbench
==================================

Name: snake_step_ctrl

Overview:
- Game-state sequencer for the one-dimensional snake on the LED strip.
- Consumes the 1 Hz move enable from the ENCOUNT divider and direction/start buttons.
- Tracks snake head, length, direction and food position, and detects eat, self-collision and win.
- Drives the LEDR[9:0] display mask, replacing the free-running shift register with game logic.

Parameters:
- N_CELLS, 10, number of cells on the ring (one per LED); minimum 3.
- IDX_W, 4, width of cell index; must satisfy 2**IDX_W >= N_CELLS.
- START_POS, 0, head cell after reset/restart.
- FOOD_STRIDE, 3, offset from the previous food cell to the first food candidate; 1..N_CELLS-1.

Ports:
- CLK1_50  in  1  system clock, 50 MHz.
- CLR  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle move enable (ENCOUNT en output).
- start  in  1  single-cycle start/restart pulse.
- dir_left  in  1  single-cycle pulse: request direction -1.
- dir_right  in  1  single-cycle pulse: request direction +1.
- led  out  N_CELLS  body mask OR food mask; bit i = cell i.
- head_idx  out  IDX_W  current head cell.
- snake_len  out  IDX_W+1  current length.
- score  out  8  foods eaten; saturates at 255.
- game_over  out  1  high in state OVER.
- game_win  out  1  high in state WIN.

Behaviour:
- Reset (CLR=1 at an edge; CLR has priority over all inputs):
  - state=IDLE, head_idx=START_POS, snake_len=1, dir=+1, pending dir=+1, prev_food=START_POS.
  - food mask=0, score=0, game_over=0, game_win=0, tick_pend=0.
  - led = one-hot(START_POS).
- CLR mid-operation in any state returns to these values at the same edge.
- Body: contiguous cells head, head-dir, ..., head-dir*(snake_len-1), all mod N_CELLS.
  - Kept as a registered N_CELLS mask, updated together with head.
- States:
  - IDLE: start -> PLACE. tick and dir pulses ignored.
  - PLACE (food search):
    - First candidate = (prev_food+FOOD_STRIDE) mod N_CELLS.
    - Each cycle: if candidate is not in body, set food mask=one-hot(candidate), prev_food=candidate, go to RUN. Otherwise candidate=(candidate+1) mod N_CELLS.
    - Completes in at most N_CELLS cycles.
    - A tick arriving in PLACE sets tick_pend. It is consumed on the first RUN cycle as if tick were high.
  - RUN: on tick (or tick_pend):
    - dir <= pending dir. next = (head+dir) mod N_CELLS; wrap 9->0 and 0->9 for N=10.
    - If body[next]=1: state OVER, nothing else changes.
    - Else if next==food:
      - head=next, body|=one-hot(next), snake_len+1, score+1, food mask=0.
      - If new snake_len==N_CELLS: WIN. Otherwise PLACE.
    - Else: head=next; body sets next and clears the old tail cell (same edge).
  - OVER / WIN: led, head and score frozen. tick and dir pulses ignored.
    - start reinitialises to reset values except state, then goes to PLACE.
- Direction input:
  - dir_right sets pending=+1; dir_left sets pending=-1.
  - Both pulses in the same cycle: ignored. Last accepted pulse before a tick wins.
  - A pulse in the same cycle as tick affects the following tick, not the current one.
  - Reversal with snake_len>=2 makes next land on a body cell -> OVER. With snake_len=1 it is legal.
- Timing:
  - Outputs are registered; they reflect a move one cycle after the tick edge.
  - game_over and game_win are never both high.

Test Plan:
1. Reset, start -> 1 PLACE cycle, food=3, led=0b0000001001. Ticks x3 -> head 1,2,3.
   - On the 3rd tick: snake_len=2, score=1, body {2,3}; PLACE picks food 6; led=0b0001001100.
2. Wrap: continue ticks until head=9, then tick -> head_idx=0, bit 9 tail handling correct, no OVER.
3. With snake_len=2 and dir=+1: dir_left pulse then tick -> game_over=1, led unchanged. Further ticks/dir pulses -> no change. start -> PLACE then RUN with snake_len=1, score=0.
4. snake_len=1 at head=1: dir_left, tick -> head=0 no OVER; next tick -> head=9. dir_left+dir_right same cycle -> direction unchanged.
5. N_CELLS=4, FOOD_STRIDE=1: start, three ticks eat foods 1,2,3 -> snake_len=4, game_win=1, led=0b1111, score=3.
6. CLR asserted during PLACE and during RUN with a tick on the same edge -> all outputs equal reset values next cycle; tick_pend cleared.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game sequencer for the 1-D snake on the LED ring.
module snake_step_ctrl #(
    parameter int N_CELLS     = 10,
    parameter int IDX_W       = 4,
    parameter int START_POS   = 0,
    parameter int FOOD_STRIDE = 3
) (
    input  logic               CLK1_50,
    input  logic               CLR,
    input  logic               tick,
    input  logic               start,
    input  logic               dir_left,
    input  logic               dir_right,
    output logic [N_CELLS-1:0] led,
    output logic [IDX_W-1:0]   head_idx,
    output logic [IDX_W:0]     snake_len,
    output logic [7:0]         score,
    output logic               game_over,
    output logic               game_win
);
    localparam int W1 = IDX_W + 1;
    localparam logic [IDX_W-1:0]   ONE_I   = 1;
    localparam logic [W1-1:0]      ONE_L   = 1;
    localparam logic [IDX_W-1:0]   LAST    = IDX_W'(N_CELLS - 1);
    localparam logic [IDX_W-1:0]   START_I = IDX_W'(START_POS);
    localparam logic [IDX_W-1:0]   CAND0   = IDX_W'((START_POS + FOOD_STRIDE) % N_CELLS);
    localparam logic [N_CELLS-1:0] ONE_M   = 1;
    localparam logic [N_CELLS-1:0] START_M = ONE_M << START_POS;

    typedef enum logic [2:0] {S_IDLE, S_PLACE, S_RUN, S_OVER, S_WIN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   head_q, head_d, prev_food_q, prev_food_d, cand_q, cand_d;
    logic [W1-1:0]      len_q, len_d;
    logic               dir_q, dir_d, pdir_q, pdir_d, tick_pend_q, tick_pend_d;
    logic [N_CELLS-1:0] body_q, body_d, food_q, food_d;
    logic [7:0]         score_q, score_d;
    logic [IDX_W-1:0]   nxt, tail;
    logic [N_CELLS-1:0] next_m, tail_m, cand_m;

    function automatic logic [IDX_W-1:0] wrap(input logic [W1-1:0] s);
        return (s >= W1'(N_CELLS)) ? IDX_W'(s - W1'(N_CELLS)) : IDX_W'(s);
    endfunction

    function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] i, input logic up);
        return up ? ((i == LAST) ? '0 : i + ONE_I) : ((i == '0) ? LAST : i - ONE_I);
    endfunction

    // body lies behind the head along the direction it was laid down in (dir_q)
    assign nxt    = step(head_q, pdir_q);
    assign tail   = dir_q ? wrap({1'b0, head_q} + W1'(N_CELLS) - len_q + ONE_L)
                          : wrap({1'b0, head_q} + len_q - ONE_L);
    assign next_m = ONE_M << nxt;
    assign tail_m = ONE_M << tail;
    assign cand_m = ONE_M << cand_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        len_d       = len_q;
        dir_d       = dir_q;
        pdir_d      = pdir_q;
        prev_food_d = prev_food_q;
        cand_d      = cand_q;
        food_d      = food_q;
        body_d      = body_q;
        score_d     = score_q;
        tick_pend_d = tick_pend_q;
        if ((state_q == S_PLACE || state_q == S_RUN) && (dir_left ^ dir_right))
            pdir_d = dir_right;
        if ((state_q == S_IDLE || state_q == S_OVER || state_q == S_WIN) && start) begin
            state_d     = S_PLACE;
            head_d      = START_I;
            len_d       = ONE_L;
            dir_d       = 1'b1;
            pdir_d      = 1'b1;
            prev_food_d = START_I;
            cand_d      = CAND0;
            food_d      = '0;
            body_d      = START_M;
            score_d     = '0;
            tick_pend_d = 1'b0;
        end else if (state_q == S_PLACE) begin
            tick_pend_d = tick_pend_q | tick;
            if (~|(body_q & cand_m)) begin
                food_d      = cand_m;
                prev_food_d = cand_q;
                state_d     = S_RUN;
            end else begin
                cand_d = step(cand_q, 1'b1);
            end
        end else if (state_q == S_RUN && (tick || tick_pend_q)) begin
            tick_pend_d = 1'b0;
            if (|(body_q & next_m)) begin
                state_d = S_OVER;
            end else begin
                dir_d  = pdir_q;
                head_d = nxt;
                if (|(food_q & next_m)) begin
                    body_d  = body_q | next_m;
                    len_d   = len_q + ONE_L;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    food_d  = '0;
                    cand_d  = wrap({1'b0, prev_food_q} + W1'(FOOD_STRIDE));
                    state_d = (len_q + ONE_L == W1'(N_CELLS)) ? S_WIN : S_PLACE;
                end else begin
                    body_d = (body_q & ~tail_m) | next_m;
                end
            end
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            state_q     <= S_IDLE;
            head_q      <= START_I;
            len_q       <= ONE_L;
            dir_q       <= 1'b1;
            pdir_q      <= 1'b1;
            prev_food_q <= START_I;
            cand_q      <= CAND0;
            food_q      <= '0;
            body_q      <= START_M;
            score_q     <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            len_q       <= len_d;
            dir_q       <= dir_d;
            pdir_q      <= pdir_d;
            prev_food_q <= prev_food_d;
            cand_q      <= cand_d;
            food_q      <= food_d;
            body_q      <= body_d;
            score_q     <= score_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    assign led       = body_q | food_q;
    assign head_idx  = head_q;
    assign snake_len = len_q;
    assign score     = score_q;
    assign game_over = (state_q == S_OVER);
    assign game_win  = (state_q == S_WIN);
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed and random stimulus against a queue-based snake model.
module tb_snake_step_ctrl;
    logic clk = 1'b0;
    logic clr, tick, start, dl, dr;
    always #5 clk = ~clk;

    logic [9:0] led_a;
    logic [3:0] head_a;
    logic [4:0] len_a;
    logic [7:0] score_a;
    logic       over_a, win_a;
    logic [3:0] led_b;
    logic [2:0] head_b;
    logic [3:0] len_b;
    logic [7:0] score_b;
    logic       over_b, win_b;

    snake_step_ctrl #(.N_CELLS(10), .IDX_W(4), .START_POS(0), .FOOD_STRIDE(3)) dut_a (
        .CLK1_50(clk), .CLR(clr), .tick(tick), .start(start), .dir_left(dl), .dir_right(dr),
        .led(led_a), .head_idx(head_a), .snake_len(len_a), .score(score_a),
        .game_over(over_a), .game_win(win_a));

    snake_step_ctrl #(.N_CELLS(4), .IDX_W(3), .START_POS(0), .FOOD_STRIDE(1)) dut_b (
        .CLK1_50(clk), .CLR(clr), .tick(tick), .start(start), .dir_left(dl), .dir_right(dr),
        .led(led_b), .head_idx(head_b), .snake_len(len_b), .score(score_b),
        .game_over(over_b), .game_win(win_b));

    int n_tests = 0, n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model: body is a queue of cells with the head at the front
    int sel, n, stride, ms, food, pf, cand, tp, pdir, score_m;
    int body[$];

    function automatic bit in_body(int c);
        foreach (body[i]) if (body[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_led();
        int m = 0;
        foreach (body[i]) m |= 1 << body[i];
        if (food >= 0) m |= 1 << food;
        return m;
    endfunction

    task automatic m_reset();
        ms = 0; body = {0}; food = -1; pf = 0; tp = 0; pdir = 1; score_m = 0; cand = 0;
    endtask

    task automatic m_step(bit c, bit t, bit s, bit l, bit r);
        int opd = pdir;
        int nx;
        if (c) begin
            m_reset();
            return;
        end
        if ((ms == 1 || ms == 2) && l != r) pdir = r ? 1 : -1;
        case (ms)
            0, 3, 4: if (s) begin
                m_reset();
                ms = 1;
                cand = stride % n;
            end
            1: begin
                if (t) tp = 1;
                if (!in_body(cand)) begin
                    food = cand; pf = cand; ms = 2;
                end else cand = (cand + 1) % n;
            end
            2: if (t || tp) begin
                tp = 0;
                nx = (body[0] + opd + n) % n;
                if (in_body(nx)) ms = 3;
                else begin
                    body.push_front(nx);
                    if (nx == food) begin
                        score_m = score_m < 255 ? score_m + 1 : 255;
                        food = -1;
                        cand = (pf + stride) % n;
                        ms = (body.size() == n) ? 4 : 1;
                    end else void'(body.pop_back());
                end
            end
            default: ;
        endcase
    endtask

    task automatic cmp();
        if (sel == 0) begin
            check("led", 32'(led_a), m_led());
            check("head", 32'(head_a), body[0]);
            check("len", 32'(len_a), body.size());
            check("score", 32'(score_a), score_m);
            check("over", 32'(over_a), 32'(ms == 3));
            check("win", 32'(win_a), 32'(ms == 4));
        end else begin
            check("led_b", 32'(led_b), m_led());
            check("head_b", 32'(head_b), body[0]);
            check("len_b", 32'(len_b), body.size());
            check("score_b", 32'(score_b), score_m);
            check("over_b", 32'(over_b), 32'(ms == 3));
            check("win_b", 32'(win_b), 32'(ms == 4));
        end
    endtask

    task automatic cyc(bit c, bit t, bit s, bit l, bit r);
        clr = c; tick = t; start = s; dl = l; dr = r;
        @(posedge clk);
        m_step(c, t, s, l, r);
        #1;
        cmp();
    endtask

    task automatic chk_reset_a(string tag);
        check({tag, "_led"}, 32'(led_a), 32'd1);
        check({tag, "_head"}, 32'(head_a), 32'd0);
        check({tag, "_len"}, 32'(len_a), 32'd1);
        check({tag, "_score"}, 32'(score_a), 32'd0);
        check({tag, "_flags"}, 32'({over_a, win_a}), 32'd0);
    endtask

    initial begin
        sel = 0; n = 10; stride = 3;
        m_reset();
        cyc(1, 0, 0, 0, 0);
        chk_reset_a("rst");
        cyc(0, 1, 0, 1, 0);
        chk_reset_a("idle_ign");
        // first food and growth
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t1_food", 32'(led_a), 32'b0000001001);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("t1_len", 32'(len_a), 32'd2);
        check("t1_score", 32'(score_a), 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("t1_led", 32'(led_a), 32'b0001001100);
        // wrap across 9 -> 0
        for (int k = 0; k < 40 && !(ms == 2 && body[0] == 9); k++) cyc(0, ms == 2, 0, 0, 0);
        check("t2_at9", 32'(head_a), 32'd9);
        cyc(0, 1, 0, 0, 0);
        check("t2_head", 32'(head_a), 32'd0);
        check("t2_led", 32'(led_a), 32'b1110000101);
        check("t2_over", 32'(over_a), 32'd0);
        // reversal into body
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check("t3_over", 32'(over_a), 32'd1);
        check("t3_led", 32'(led_a), 32'b1110000101);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 1, 0);
        check("t3_frozen", 32'(head_a), 32'd0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t3_len", 32'(len_a), 32'd1);
        check("t3_score", 32'(score_a), 32'd0);
        // length-1 reversal and simultaneous pulses
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check("t4_h0", 32'(head_a), 32'd0);
        cyc(0, 1, 0, 0, 0);
        check("t4_h9", 32'(head_a), 32'd9);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0);
        check("t4_h8", 32'(head_a), 32'd8);
        check("t4_over", 32'(over_a), 32'd0);
        // CLR in RUN and PLACE with tick on the same edge
        cyc(1, 1, 0, 0, 0);
        chk_reset_a("t6_run");
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk_reset_a("t6_place");
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t6_pend", 32'(head_a), 32'd0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        // small ring: fill to win
        sel = 1; n = 4; stride = 1;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0);
        end
        check("t5_win", 32'(win_b), 32'd1);
        check("t5_led", 32'(led_b), 32'b1111);
        check("t5_score", 32'(score_b), 32'd3);
        check("t5_len", 32'(len_b), 32'd4);
        check("t5_over", 32'(over_b), 32'd0);
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
